// File: rtl/multicycle_chunk_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock through a ripple chain of
// full-adder cells, LSB chunk first, registered carry between chunks.

module mca_fa_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);
    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

module multicycle_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             ovf_o,
    output logic             busy_o
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_a, r_b, r_work, r_sum;
    logic             r_cy, r_carry, r_ovf;

    logic             w_accept, w_last;
    logic [CHUNK-1:0] w_ca, w_cb, w_cs;
    logic [CHUNK:0]   w_c;
    logic [WIDTH-1:0] w_work_nxt;

    assign w_accept = in_valid_i && (r_state == S_IDLE);
    assign w_last   = (r_idx == LAST_IDX);

    assign w_ca   = r_a[int'(r_idx) * CHUNK +: CHUNK];
    assign w_cb   = r_b[int'(r_idx) * CHUNK +: CHUNK];
    assign w_c[0] = r_cy;

    for (genvar g = 0; g < CHUNK; g++) begin : g_fa
        mca_fa_cell u_fa (
            .i_a  (w_ca[g]),
            .i_b  (w_cb[g]),
            .i_ci (w_c[g]),
            .o_s  (w_cs[g]),
            .o_co (w_c[g+1])
        );
    end

    // Full working word with the current chunk merged in; committed on the last chunk.
    always_comb begin
        w_work_nxt = r_work;
        w_work_nxt[int'(r_idx) * CHUNK +: CHUNK] = w_cs;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid_i) w_state_nxt = S_ADD;
            S_ADD:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_cy    <= 1'b0;
            r_work  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            // Subtract as A + ~B + 1: invert B once here, seed the carry with 1.
            r_a   <= a_i;
            r_b   <= sub_i ? ~b_i : b_i;
            r_cy  <= sub_i ? 1'b1 : c_i;
            r_idx <= '0;
        end else if (r_state == S_ADD) begin
            r_work <= w_work_nxt;
            r_cy   <= w_c[CHUNK];
            if (w_last) begin
                r_sum   <= w_work_nxt;
                r_carry <= w_c[CHUNK];
                r_ovf   <= w_c[CHUNK] ^ w_c[CHUNK-1];
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign in_ready_o  = (r_state == S_IDLE);
    assign busy_o      = (r_state != S_IDLE);
    assign out_valid_o = (r_state == S_DONE);
    assign sum_o       = r_sum;
    assign carry_o     = r_carry;
    assign ovf_o       = r_ovf;
endmodule
